// File: rtl/e_stage_muldiv_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit:
// operation encodings, FSM state encoding and the default datapath width.
package e_stage_muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/e_stage_muldiv_datapath.sv
// Iterative magnitude datapath: shift-add multiply and restoring divide
// share one 2*XLEN accumulator, retiring BITS_PER_CYCLE bits per RUN cycle.
module e_stage_muldiv_datapath
  import e_stage_muldiv_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              run_i,
  input  logic              div_i,
  input  logic [XLEN-1:0]   a_mag_i,
  input  logic [XLEN-1:0]   b_mag_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              last_o
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              div_q;
  logic [CNT_W-1:0]  cnt_q;

  // Multiply: acc = {partial product, remaining multiplier bits}, LSB decides the add.
  // Divide:   acc = {partial remainder, dividend/quotient bits}, borrow decides the restore.
  function automatic logic [2*XLEN-1:0] md_step(input logic [2*XLEN-1:0] acc,
                                                input logic [XLEN-1:0]   opnd,
                                                input logic              is_div);
    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    trial = acc[2*XLEN-1:XLEN-1];
    diff  = trial - {1'b0, opnd};
    if (is_div) begin
      md_step = diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    end else begin
      md_step = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    end
  endfunction

  logic [2*XLEN-1:0] stage [0:BITS_PER_CYCLE];

  assign stage[0] = acc_q;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    assign stage[gi+1] = md_step(stage[gi], opnd_q, div_q);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load_i) begin
      acc_q  <= div_i ? {{XLEN{1'b0}}, a_mag_i} : {{XLEN{1'b0}}, b_mag_i};
      opnd_q <= div_i ? b_mag_i : a_mag_i;
      div_q  <= div_i;
      cnt_q  <= CNT_W'(ITERS);
    end else if (run_i) begin
      acc_q <= stage[BITS_PER_CYCLE];
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/e_stage_muldiv.sv
// Execute-stage multiply/divide unit: FSM, HI/LO, stall/done and sign handling.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they run as MULTU/DIVU.
module e_stage_muldiv
  import e_stage_muldiv_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_e,
  input  logic [1:0]      op_e,
  input  logic [XLEN-1:0] a_e,
  input  logic [XLEN-1:0] b_e,
  input  logic            flush_e,
  input  logic            mthi_e,
  input  logic            mtlo_e,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e         state_q, state_d;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic [XLEN-1:0]   a_raw_q;
  logic              dz_q;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   res_hi, res_lo;
  logic [2*XLEN-1:0] acc;
  logic              last;
  logic              accept, is_div, dz_now, mt_ok;

  assign is_div = (op_e == MD_DIVU) || (op_e == MD_DIV);
  assign dz_now = is_div && (b_e == '0);
  assign accept = (state_q == IDLE) && start_e && !flush_e;
  // A start in IDLE wins over a (decoder-impossible) simultaneous MTHI/MTLO.
  assign mt_ok  = !flush_e && (((state_q == IDLE) && !start_e) || (state_q == DONE));

`ifdef MULDIV_SIGNED_EN
  logic signed_op, sgn_a, sgn_b;
  logic neg_q_q, neg_r_q, div_q;

  assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign sgn_a     = signed_op && a_e[XLEN-1];
  assign sgn_b     = signed_op && b_e[XLEN-1];
  assign a_mag     = sgn_a ? -a_e : a_e;
  assign b_mag     = sgn_b ? -b_e : b_e;
`else
  assign a_mag = a_e;
  assign b_mag = b_e;
`endif

  e_stage_muldiv_datapath #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .run_i   ((state_q == RUN) && !flush_e),
    .div_i   (is_div),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .acc_o   (acc),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dz_now ? FIX : RUN;
      RUN:     if (flush_e) state_d = IDLE;
               else if (last) state_d = FIX;
      FIX:     state_d = flush_e ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divide by zero bypasses the datapath: HI keeps the raw dividend.
  always_comb begin
    res_hi = acc[2*XLEN-1:XLEN];
    res_lo = acc[XLEN-1:0];
    if (dz_q) begin
      res_hi = a_raw_q;
      res_lo = '1;
    end
`ifdef MULDIV_SIGNED_EN
    else if (div_q) begin
      if (neg_q_q) res_lo = -acc[XLEN-1:0];
      if (neg_r_q) res_hi = -acc[2*XLEN-1:XLEN];
    end else if (neg_q_q) begin
      {res_hi, res_lo} = -acc;
    end
`endif
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_raw_q <= '0;
      dz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_raw_q <= a_e;
        dz_q    <= dz_now;
`ifdef MULDIV_SIGNED_EN
        neg_q_q <= sgn_a ^ sgn_b;
        neg_r_q <= sgn_a;
        div_q   <= is_div;
`endif
      end
      if ((state_q == FIX) && !flush_e) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (mt_ok) begin
        if (mthi_e) hi_q <= a_e;
        if (mtlo_e) lo_q <= a_e;
      end
    end
  end

  assign stall = accept || (state_q == RUN) || (state_q == FIX);
  assign busy  = (state_q == RUN) || (state_q == FIX);
  assign done  = (state_q == DONE);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_e_stage_muldiv.sv
// Directed bench for e_stage_muldiv: latency, stall length, results, flush, reset, MTHI/MTLO.
module tb_e_stage_muldiv;

  logic        clk;
  logic        rst;
  logic        start_e;
  logic [1:0]  op_e;
  logic [31:0] a_e;
  logic [31:0] b_e;
  logic        flush_e;
  logic        mthi_e;
  logic        mtlo_e;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed;
  int total;
  int done_cnt;
  int base;

  e_stage_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start_e (start_e),
    .op_e    (op_e),
    .a_e     (a_e),
    .b_e     (b_e),
    .flush_e (flush_e),
    .mthi_e  (mthi_e),
    .mtlo_e  (mtlo_e),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The DUT updates on the falling edge; the rising edge is a safe sample point.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called in IDLE. Latency counts cycles from the accepting cycle to the done cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit hold);
    int n;
    int st;
    n  = 0;
    st = 0;
    op_e    = op;
    a_e     = a;
    b_e     = b;
    start_e = 1'b1;
    #1;
    chk({tag, "_stall_accept"}, 64'(stall), 64'd1);
    while (n < 100) begin
      cyc();
      n++;
      if (n == 1) begin
        a_e = ~a;
        b_e = ~b;
      end
      if (done) break;
      if (stall) st++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_stall_cycles"}, 64'(st), 64'(exp_lat - 1));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_stall_in_done"}, 64'(stall), 64'd0);
    $display("op %s a=%h b=%h latency=%0d stall_cycles=%0d hi=%h lo=%h", tag, a, b, n, st, hi, lo);
    if (!hold) begin
      start_e = 1'b0;
      cyc();
      chk({tag, "_done_pulse_end"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    done_cnt = 0;
    rst      = 1'b1;
    start_e  = 1'b0;
    op_e     = 2'b00;
    a_e      = '0;
    b_e      = '0;
    flush_e  = 1'b0;
    mthi_e   = 1'b0;
    mtlo_e   = 1'b0;
    cyc();
    cyc();
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    $display("reset hi=%h lo=%h busy=%b stall=%b", hi, lo, busy, stall);
    rst = 1'b0;
    cyc();

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5, 34, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0);
`else
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5, 34, 32'h00000004, 32'hFFFFFFF1, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 34, 32'h00000001, 32'h7FFFFFFC, 1'b0);
    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000, 32'h00000000, 1'b0);
`endif
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
    run_op("divu_by_zero", 2'b10, 32'h00001234, 32'd0, 2, 32'h00001234, 32'hFFFFFFFF, 1'b0);

    mtlo_e = 1'b1;
    a_e    = 32'h00005555;
    cyc();
    mtlo_e = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h5555);
    mthi_e = 1'b1;
    a_e    = 32'h0000AAAA;
    cyc();
    mthi_e = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hAAAA);
    $display("mthi/mtlo hi=%h lo=%h", hi, lo);

    base    = done_cnt;
    op_e    = 2'b00;
    a_e     = 32'd3;
    b_e     = 32'd4;
    start_e = 1'b1;
    cyc();
    repeat (9) cyc();
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush_e = 1'b1;
    cyc();
    flush_e = 1'b0;
    start_e = 1'b0;
    #1;
    chk("flush_stall_after", 64'(stall), 64'd0);
    chk("flush_busy_after", 64'(busy), 64'd0);
    repeat (40) cyc();
    chk("flush_no_done", 64'(done_cnt - base), 64'd0);
    chk("flush_hi_kept", 64'(hi), 64'hAAAA);
    chk("flush_lo_kept", 64'(lo), 64'h5555);
    $display("flush multu 3x4 hi=%h lo=%h dones=%0d", hi, lo, done_cnt - base);

    op_e    = 2'b10;
    a_e     = 32'd50;
    b_e     = 32'd5;
    start_e = 1'b1;
    cyc();
    repeat (4) cyc();
    rst     = 1'b1;
    start_e = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    $display("reset mid-divu hi=%h lo=%h stall=%b", hi, lo, stall);
    cyc();
    rst = 1'b0;
    cyc();
    run_op("divu_50_5", 2'b10, 32'd50, 32'd5, 34, 32'd0, 32'd10, 1'b0);

    base = done_cnt;
    run_op("b2b_multu", 2'b00, 32'd2, 32'd3, 34, 32'd0, 32'd6, 1'b1);
    op_e = 2'b10;
    a_e  = 32'd9;
    b_e  = 32'd2;
    #1;
    chk("b2b_stall_in_done", 64'(stall), 64'd0);
    cyc();
    run_op("b2b_divu", 2'b10, 32'd9, 32'd2, 34, 32'd1, 32'd4, 1'b0);
    chk("b2b_done_count", 64'(done_cnt - base), 64'd2);
    $display("back-to-back dones=%0d", done_cnt - base);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
